// File: rtl/decod_pkg.sv
// Shared arbiter/decoder definitions: FSM state encoding, grant code
// constants and the hold-counter width.
package decod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_REQ0 = 2'd1;
  localparam logic [1:0] CODE_REQ1 = 2'd2;
  localparam logic [1:0] CODE_REQ2 = 2'd3;

  localparam int unsigned HOLD_W = 4;

  // Index reset value of "last": requester 0 searched first.
  localparam logic [1:0] LAST_RST = 2'd2;

endpackage

// File: rtl/decodificador.sv
// Grant code decoder: 2-bit code -> 8-bit one-hot grant pattern.
// Ports: code (in, 2b), pattern (out, 8b; 0 for CODE_NONE).
module decodificador
  import decod_pkg::*;
(
  input  logic [1:0] code,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = 8'b0;
    unique case (code)
      CODE_NONE: pattern = 8'b0000_0000;
      CODE_REQ0: pattern = 8'b0000_0001;
      CODE_REQ1: pattern = 8'b0000_0010;
      CODE_REQ2: pattern = 8'b0000_0100;
      default:   pattern = 8'b0000_0000;
    endcase
  end

endmodule

// File: rtl/arbitro_decodificador.sv
// Round-robin 3-way arbiter with bounded hold and a one-cycle gap
// between owners, plus a decoded grant pattern.
// Ports: p_Clock, p_Reset (sync, active high), p_Req[2:0] (in);
//        p_Code[1:0] registered code, p_Output[7:0] decode, p_Busy (out).
module arbitro_decodificador
  import decod_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       p_Clock,
  input  logic       p_Reset,
  input  logic [2:0] p_Req,
  output logic [1:0] p_Code,
  output logic [7:0] p_Output,
  output logic       p_Busy
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state;
  state_t            state_n;
  logic [1:0]        code;
  logic [1:0]        code_n;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_n;
  logic [1:0]        last;
  logic [1:0]        last_n;

  logic       any_req;
  logic       owner_req;
  logic       expire;
  logic       leave;
  logic [1:0] owner;
  logic [1:0] winner;

  // First requester found scanning upward from last+1, with wrap.
  function automatic logic [1:0] rr_pick(
    input logic [2:0] req,
    input logic [1:0] prev
  );
    logic [1:0] pick;
    logic       found;
    int         cand;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cand = (int'(prev) + 1 + k) % 3;
      if (!found && req[cand]) begin
        pick  = 2'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_req = |p_Req;
  assign winner  = rr_pick(p_Req, last);
  assign owner   = code - 2'd1;

  // Only the owner's bit matters while granted; others are ignored.
  always_comb begin
    owner_req = 1'b0;
    unique case (code)
      CODE_REQ0: owner_req = p_Req[0];
      CODE_REQ1: owner_req = p_Req[1];
      CODE_REQ2: owner_req = p_Req[2];
      default:   owner_req = 1'b0;
    endcase
  end

  assign expire = (cnt == HOLD_LAST);
  // Release and expiry collapse into one exit condition.
  assign leave  = !owner_req || expire;

  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      state <= IDLE;
      code  <= CODE_NONE;
      cnt   <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_n;
      code  <= code_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, GAP: state_n = any_req ? GRANT : IDLE;
      GRANT:     state_n = leave ? GAP : GRANT;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    code_n = code;
    cnt_n  = cnt;
    last_n = last;
    p_Busy = (state == GRANT);
    unique case (state)
      IDLE, GAP: begin
        if (any_req) begin
          code_n = winner + 2'd1;
          cnt_n  = '0;
        end else begin
          code_n = CODE_NONE;
        end
      end
      GRANT: begin
        if (leave) begin
          code_n = CODE_NONE;
          last_n = owner;
        end else begin
          cnt_n  = cnt + 1'b1;
        end
      end
      default: begin
        code_n = CODE_NONE;
        cnt_n  = '0;
      end
    endcase
  end

  assign p_Code = code;

  decodificador u_dec (
    .code    (code),
    .pattern (p_Output)
  );

endmodule
